mem_access_ctrl: RTL and testbench

CPU-side access controller that sits directly upstream of the 32x16 data memory. It accepts single-word read/write requests from the CPU core over a ready/done handshake and sequences the memory's memrq/rw/addr/in_data pins. It captures read data from the memory's combinational out_data into a held register and range-checks addresses against the physical depth. Out-of-range requests return an error pulse and never touch memory.

---
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-word CPU access controller in front of the 32x16 data memory.
// Sequences memrq/rw/addr/in_data, range-checks addresses and holds the last read word.
module mem_access_ctrl #(
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_memrq,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in_data,
    input  logic [DATA_W-1:0] mem_out_data
);

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              mem_memrq_q, mem_memrq_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_in_data_q, mem_in_data_d;

    logic accept;
    logic addr_oob;

    assign accept   = (state_q == IDLE) && cpu_ready_q && cpu_req;
    assign addr_oob = ({1'b0, cpu_addr} >= DEPTH_EXT);

    // NOTE: every flop updates with <= so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cpu_ready_q   <= 1'b0;
            cpu_done_q    <= 1'b0;
            cpu_err_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            mem_memrq_q   <= 1'b0;
            mem_rw_q      <= 1'b1;
            mem_addr_q    <= '0;
            mem_in_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_ready_q   <= cpu_ready_d;
            cpu_done_q    <= cpu_done_d;
            cpu_err_q     <= cpu_err_d;
            cpu_rdata_q   <= cpu_rdata_d;
            mem_memrq_q   <= mem_memrq_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_in_data_q <= mem_in_data_d;
        end
    end

    // NOTE: a default assignment heads each always_comb so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_oob)    state_d = ERR;
                    else if (cpu_we) state_d = WR;
                    else             state_d = RD;
                end
            end
            RD:        if (cnt_q == '0) state_d = DONE;
            WR:        state_d = DONE;
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the memory pins idle at memrq=0, rw=1.
    always_comb begin
        cnt_d         = cnt_q;
        cpu_ready_d   = 1'b0;
        cpu_done_d    = 1'b0;
        cpu_err_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        mem_memrq_d   = 1'b0;
        mem_rw_d      = 1'b1;
        mem_addr_d    = mem_addr_q;
        mem_in_data_d = mem_in_data_q;
        case (state_q)
            IDLE: begin
                cpu_ready_d = !accept;
                if (accept) begin
                    mem_addr_d    = cpu_addr;
                    mem_in_data_d = cpu_wdata;
                    if (addr_oob) begin
                        cpu_done_d = 1'b1;
                        cpu_err_d  = 1'b1;
                    end else if (cpu_we) begin
                        mem_memrq_d = 1'b1;
                        mem_rw_d    = 1'b0;
                    end else begin
                        mem_memrq_d = 1'b1;
                        cnt_d       = WAIT_INIT;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    cpu_rdata_d = mem_out_data;
                    cpu_done_d  = 1'b1;
                end else begin
                    mem_memrq_d = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end
            end
            WR:        cpu_done_d = 1'b1;
            DONE, ERR: cpu_ready_d = 1'b1;
            default: ;
        endcase
    end

    assign cpu_ready   = cpu_ready_q;
    assign cpu_done    = cpu_done_q;
    assign cpu_err     = cpu_err_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign mem_memrq   = mem_memrq_q;
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_in_data = mem_in_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two builds (WAIT_CYCLES=1 and 3), each with a 32x16 memory model,
// a driver that queues expected completions and a monitor that checks every cpu_done.
module tb_mem_access_ctrl;

    typedef struct {
        int          inst;
        logic        err;
        logic [15:0] rdata;
        int          lat;
        int          rd_n;
        int          wr_n;
        logic [11:0] addr;
    } exp_t;

    typedef struct {
        int inst;
        int cyc;
    } acc_t;

    logic        clk;
    logic        rst;
    logic        req [2];
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        ready [2];
    logic        done [2];
    logic        err [2];
    logic [15:0] rdata [2];
    logic        memrq [2];
    logic        rw [2];
    logic [11:0] maddr [2];
    logic [15:0] mindata [2];
    logic [15:0] mout [2];

    logic [15:0] mem [2][32];
    logic [15:0] exp_mem [2][32];
    logic [15:0] exp_rd [2];

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   cyc;
    int   rd_n [2];
    int   wr_n [2];
    int   n_total;
    int   n_pass;

    mem_access_ctrl #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .cpu_req(req[0]), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(ready[0]), .cpu_done(done[0]), .cpu_err(err[0]),
        .cpu_rdata(rdata[0]), .mem_memrq(memrq[0]), .mem_rw(rw[0]), .mem_addr(maddr[0]),
        .mem_in_data(mindata[0]), .mem_out_data(mout[0])
    );

    mem_access_ctrl #(.WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst), .cpu_req(req[1]), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(ready[1]), .cpu_done(done[1]), .cpu_err(err[1]),
        .cpu_rdata(rdata[1]), .mem_memrq(memrq[1]), .mem_rw(rw[1]), .mem_addr(maddr[1]),
        .mem_in_data(mindata[1]), .mem_out_data(mout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: combinational read, write at the edge ending a memrq && !rw cycle.
    assign mout[0] = mem[0][maddr[0][4:0]];
    assign mout[1] = mem[1][maddr[1][4:0]];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) mem[k][i] <= 16'h0000;
            end else if (memrq[k] && !rw[k]) begin
                mem[k][maddr[k][4:0]] <= mindata[k];
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: logs acceptances, counts memrq cycles, and checks each completion.
    always @(negedge clk) begin
        exp_t e;
        acc_t a;
        for (int k = 0; k < 2; k++) begin
            if (memrq[k]) begin
                if (rw[k]) rd_n[k]++;
                else       wr_n[k]++;
            end
            if (err[k]) check("err_with_done", longint'(done[k]), 1);
            if (done[k]) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_done", longint'(done[k]), 0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("done_instance", k, e.inst);
                    check("cpu_err", longint'(err[k]), longint'(e.err));
                    check("latency", cyc - a.cyc, e.lat);
                    check("cpu_rdata", longint'(rdata[k]), longint'(e.rdata));
                    check("memrq_read_cycles", rd_n[k], e.rd_n);
                    check("memrq_write_cycles", wr_n[k], e.wr_n);
                    check("mem_addr_held", longint'(maddr[k]), longint'(e.addr));
                end
            end
            if (rst) begin
                rd_n[k] = 0;
                wr_n[k] = 0;
            end else if (ready[k] && req[k]) begin
                acc_q.push_back('{k, cyc});
                rd_n[k] = 0;
                wr_n[k] = 0;
            end
        end
        if (rst) acc_q.delete();
    end

    // Reference model of one request: latency, memrq cycles and resulting cpu_rdata.
    task automatic expect_req(input int k, input logic we, input logic [11:0] a, input logic [15:0] d);
        exp_t e;
        int   w;
        w      = (k == 0) ? 1 : 3;
        e.inst = k;
        e.addr = a;
        e.err  = (a >= 12'd32);
        if (e.err) begin
            e.lat = 1; e.rd_n = 0; e.wr_n = 0;
        end else if (we) begin
            e.lat = 2; e.rd_n = 0; e.wr_n = 1;
            exp_mem[k][a[4:0]] = d;
        end else begin
            e.lat = w + 2; e.rd_n = w + 1; e.wr_n = 0;
            exp_rd[k] = exp_mem[k][a[4:0]];
        end
        e.rdata = exp_rd[k];
        exp_q.push_back(e);
    endtask

    // Called and returns at posedge+1.
    task automatic wait_ready(input int k);
        int g = 0;
        while (!ready[k] && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (!ready[k]) check("ready_timeout", longint'(ready[k]), 1);
    endtask

    task automatic issue(input int k, input logic we, input logic [11:0] a, input logic [15:0] d);
        wait_ready(k);
        expect_req(k, we, a, d);
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        req[k]    = 1'b1;
        @(posedge clk); #1;
        req[k]    = 1'b0;
    endtask

    initial begin
        int g;
        n_total = 0; n_pass = 0; cyc = 0;
        rd_n[0] = 0; rd_n[1] = 0; wr_n[0] = 0; wr_n[1] = 0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) exp_mem[k][i] = 16'h0;
        rst = 1'b1; req[0] = 1'b0; req[1] = 1'b0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", longint'(ready[0]), 0);
        check("rst_memrq", longint'(memrq[0]), 0);
        check("rst_rw", longint'(rw[0]), 1);
        check("rst_done", longint'(done[0]), 0);
        check("rst_rdata", longint'(rdata[0]), 0);
        check("rst_mem_addr", longint'(maddr[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_release", longint'(ready[0]), 1);

        // Abandon a read with a two-cycle reset; no completion may follow.
        cpu_we = 1'b0; cpu_addr = 12'd3; req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("rd_memrq_before_rst", longint'(memrq[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("memrq_dropped_by_rst", longint'(memrq[0]), 0);
        @(posedge clk); #1;
        check("ready_in_rst", longint'(ready[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_mid_rst", longint'(ready[0]), 1);
        check("rdata_after_mid_rst", longint'(rdata[0]), 0);
        repeat (4) @(posedge clk);
        #1;

        issue(0, 1'b1, 12'd5, 16'hBEEF);
        issue(0, 1'b0, 12'd5, 16'h0000);
        issue(0, 1'b1, 12'd31, 16'h1234);
        issue(0, 1'b0, 12'd31, 16'h0000);
        issue(0, 1'b0, 12'd32, 16'h0000);
        issue(0, 1'b0, 12'hFFF, 16'h0000);

        // cpu_req held high for 9 cycles of writes to 10..18. Writes take a 3-cycle
        // round trip (accept, WR, DONE), so only indices 0, 3 and 6 are accepted.
        wait_ready(0);
        expect_req(0, 1'b1, 12'd10, 16'h1000);
        expect_req(0, 1'b1, 12'd13, 16'h1003);
        expect_req(0, 1'b1, 12'd16, 16'h1006);
        for (int i = 0; i < 9; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = 12'(10 + i);
            cpu_wdata = 16'h1000 + 16'(i);
            req[0]    = 1'b1;
            @(posedge clk); #1;
        end
        req[0] = 1'b0;
        for (int i = 0; i < 9; i++) issue(0, 1'b0, 12'(10 + i), 16'h0000);

        issue(0, 1'b1, 12'd20, 16'hA5A5);
        issue(0, 1'b0, 12'd20, 16'h0000);
        issue(0, 1'b1, 12'd21, 16'h5555);
        issue(0, 1'b0, 12'd40, 16'h0000);
        wait_ready(0);
        check("rdata_held_a5a5", longint'(rdata[0]), 16'hA5A5);

        issue(1, 1'b1, 12'd2, 16'h7777);
        issue(1, 1'b0, 12'd2, 16'h0000);
        issue(1, 1'b0, 12'd40, 16'h0000);

        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("pending_completions", exp_q.size(), 0);
        check("rdata_w3_final", longint'(rdata[1]), 16'h7777);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
